// File: rtl/sum_accum_16.sv
// Streaming 16-bit word summer: adds N_WORDS unsigned words, counts carry-outs
// (saturating, with sticky flag), and holds the result until the consumer takes it.
module sum_accum_16 #(
  parameter int N_WORDS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_sat,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [15:0] LAST_IDX = N_WORDS[15:0];

  state_t           state, state_nx;
  logic [15:0]      acc, acc_nx;
  logic [CNT_W-1:0] carries, carries_nx;
  logic             sat, sat_nx;
  logic [15:0]      idx, idx_nx;
  logic [16:0]      sum17;
  logic [15:0]      idx_inc;
  logic [CNT_W:0]   cnt_upd;
  logic             in_xfer;

  // Returns {hit_at_max, new_count}; the count sticks at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic c);
    if (!c)
      return {1'b0, cnt};
    else if (&cnt)
      return {1'b1, cnt};
    else
      return {1'b0, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
  endfunction

  assign in_ready    = (state != HOLD);
  assign out_valid   = (state == HOLD);
  assign busy        = (state != IDLE);
  assign out_sum     = acc;
  assign out_carries = carries;
  assign out_sat     = sat;

  assign in_xfer = in_valid & in_ready;
  assign sum17   = {1'b0, acc} + {1'b0, in_data};
  assign idx_inc = idx + 16'd1;
  assign cnt_upd = sat_inc(carries, sum17[16]);

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    carries_nx = carries;
    sat_nx     = sat;
    idx_nx     = idx;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          acc_nx     = in_data;
          carries_nx = '0;
          sat_nx     = 1'b0;
          idx_nx     = 16'd1;
          state_nx   = ACC;
        end
      end
      ACC: begin
        if (in_xfer) begin
          acc_nx     = sum17[15:0];
          carries_nx = cnt_upd[CNT_W-1:0];
          sat_nx     = sat | cnt_upd[CNT_W];
          idx_nx     = idx_inc;
          if (idx_inc == LAST_IDX)
            state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over any simultaneous input or output transfer.
    if (clr) begin
      state_nx   = IDLE;
      acc_nx     = '0;
      carries_nx = '0;
      sat_nx     = 1'b0;
      idx_nx     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      carries <= '0;
      sat     <= 1'b0;
      idx     <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      carries <= carries_nx;
      sat     <= sat_nx;
      idx     <= idx_nx;
    end
  end

endmodule

// File: tb/tb_sum_accum_16.sv
// Directed bench for sum_accum_16: a 4-word instance for protocol/function
// scenarios and a 300-word instance for carry-counter saturation.
module tb_sum_accum_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, in_valid, in_ready, out_valid, out_ready, out_sat, busy;
  logic [15:0] in_data, out_sum;
  logic [7:0]  out_carries;

  logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_busy;
  logic [15:0] b_in_data, b_out_sum;
  logic [7:0]  b_out_carries;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_accum_16 #(.N_WORDS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carries(out_carries), .out_sat(out_sat), .busy(busy)
  );

  sum_accum_16 #(.N_WORDS(300), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_carries(b_out_carries), .out_sat(b_out_sat), .busy(b_busy)
  );

  // Present one word to the 4-word instance for one edge; in_ready must be high.
  task automatic send_a(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_a_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] w);
    b_in_valid = 1'b1;
    b_in_data  = w;
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_b_ready: in_ready=%b required 1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic consume_a();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL consume: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_ctrl: vld=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready); end
    checks++;
    if (out_sum !== 16'h0 || out_carries !== 8'h0 || out_sat !== 1'b0)
      begin failures++; $display("FAIL reset_data: sum=%h car=%0d sat=%b required 0000 0 0", out_sum, out_carries, out_sat); end
  endtask

  task automatic test_basic();
    send_a(16'h0001);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: busy=%b required 1", busy); end
    send_a(16'h0002);
    send_a(16'h0003);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early: out_valid=%b required 0", out_valid); end
    send_a(16'h0004);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
      begin failures++; $display("FAIL basic_hold: vld=%b rdy=%b busy=%b required 1 0 1", out_valid, in_ready, busy); end
    checks++;
    if (out_sum !== 16'h000A || out_carries !== 8'd0 || out_sat !== 1'b0)
      begin failures++; $display("FAIL basic_sum: sum=%h car=%0d sat=%b required 000a 0 0", out_sum, out_carries, out_sat); end
    consume_a();
  endtask

  task automatic test_carries();
    for (int i = 0; i < 4; i++) send_a(16'hFFFF);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'hFFFC || out_carries !== 8'd3 || out_sat !== 1'b0)
      begin failures++; $display("FAIL carries: vld=%b sum=%h car=%0d sat=%b required 1 fffc 3 0", out_valid, out_sum, out_carries, out_sat); end
    consume_a();
  endtask

  task automatic test_back_to_back();
    send_a(16'h0005); send_a(16'h0006); send_a(16'h0007); send_a(16'h0008);
    in_valid = 1'b1;
    in_data  = 16'h0099;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'h001A)
        begin failures++; $display("FAIL stall_%0d: rdy=%b vld=%b sum=%h required 0 1 001a", i, in_ready, out_valid, out_sum); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL bubble: vld=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_sum !== 16'h0099)
      begin failures++; $display("FAIL after_bubble: busy=%b sum=%h required 1 0099", busy, out_sum); end
    send_a(16'h0001); send_a(16'h0001); send_a(16'h0001);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h009C)
      begin failures++; $display("FAIL b2b_sum: vld=%b sum=%h required 1 009c", out_valid, out_sum); end
    consume_a();
  endtask

  task automatic test_clr();
    send_a(16'h0100); send_a(16'h0200);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h0777;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_sum !== 16'h0000 || out_valid !== 1'b0)
      begin failures++; $display("FAIL clr_acc: busy=%b sum=%h vld=%b required 0 0000 0", busy, out_sum, out_valid); end
    for (int i = 0; i < 4; i++) send_a(16'h0001);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0004 || out_carries !== 8'd0)
      begin failures++; $display("FAIL clr_resum: vld=%b sum=%h car=%0d required 1 0004 0", out_valid, out_sum, out_carries); end
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'h0000)
      begin failures++; $display("FAIL clr_hold: vld=%b busy=%b sum=%h required 0 0 0000", out_valid, busy, out_sum); end
  endtask

  task automatic test_async_reset();
    send_a(16'h1234); send_a(16'h1111);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h0000 || out_valid !== 1'b0)
      begin failures++; $display("FAIL async_rst: busy=%b rdy=%b sum=%h vld=%b required 0 1 0000 0", busy, in_ready, out_sum, out_valid); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_a(16'h0010);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0040 || out_carries !== 8'd0)
      begin failures++; $display("FAIL post_rst_sum: vld=%b sum=%h car=%0d required 1 0040 0", out_valid, out_sum, out_carries); end
    consume_a();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) send_b(16'hFFFF);
    checks++;
    if (b_out_carries !== 8'd255 || b_out_sat !== 1'b0)
      begin failures++; $display("FAIL sat_edge: car=%0d sat=%b required 255 0", b_out_carries, b_out_sat); end
    for (int i = 0; i < 43; i++) send_b(16'hFFFF);
    checks++;
    if (b_out_valid !== 1'b0 || b_out_sat !== 1'b1)
      begin failures++; $display("FAIL sat_299: vld=%b sat=%b required 0 1", b_out_valid, b_out_sat); end
    send_b(16'hFFFF);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_sum !== 16'hFED4 || b_out_carries !== 8'd255 || b_out_sat !== 1'b1)
      begin failures++; $display("FAIL sat_final: vld=%b sum=%h car=%0d sat=%b required 1 fed4 255 1", b_out_valid, b_out_sum, b_out_carries, b_out_sat); end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checks++;
    if (b_out_valid !== 1'b0) begin failures++; $display("FAIL sat_consume: vld=%b required 0", b_out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_carries();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_accum_16.md
SUM_ACCUM_16 -- requirements
Module: sum_accum_16

Interface
REQ-001 SHALL have parameter: N_WORDS, 4, words summed per result; legal range 2..65535.
REQ-002 SHALL have parameter: CNT_W, 8, width of carry counter out_carries.
REQ-003 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: clr  input  1  synchronous abort; discards partial or held result.
REQ-006 SHALL have port: in_valid  input  1  in_data valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port: in_data  input  16  unsigned operand word.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: out_sum  output  16  low 16 bits of word total.
REQ-012 SHALL have port: out_carries  output  CNT_W  count of carry-outs from bit 15.
REQ-013 SHALL have port: out_sat  output  1  out_carries saturated.
REQ-014 SHALL have port: busy  output  1  high in ACC or HOLD.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, HOLD; transfer occurs on a valid&ready cycle.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACC, 0 in HOLD; in_ready SHALL NOT depend on in_valid.
REQ-017 IDLE: on input transfer SHALL load acc=in_data, carries=0, sat=0, idx=1, go ACC.
REQ-018 ACC: on input transfer SHALL compute 17-bit {c,acc}=acc+in_data, carries+=c, idx+=1.
REQ-019 carries SHALL saturate at 2^CNT_W-1; a carry at saturation SHALL set sticky sat.
REQ-020 ACC: transfer making idx==N_WORDS SHALL go HOLD; out_valid SHALL rise the next cycle (latency 1 from last accepted word).
REQ-021 ACC with in_valid=0 SHALL hold all state (no timeout).
REQ-022 HOLD: out_valid=1; out_sum, out_carries, out_sat SHALL be stable until transfer.
REQ-023 HOLD: on out_ready=1 SHALL go IDLE; out_valid low next cycle; one-cycle bubble before next accept.
REQ-024 out_sum/out_carries/out_sat SHALL reflect internal registers at all times; qualified only by out_valid.
REQ-025 clr=1 in any state SHALL go IDLE next cycle, zero acc/carries/sat/idx, drop out_valid; clr SHALL override simultaneous input or output transfer (word not accepted, result lost).
REQ-026 busy SHALL be 1 in ACC and HOLD, 0 in IDLE.
REQ-027 idx counter SHALL be 16 bits; no wrap possible within legal N_WORDS.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, acc=0, carries=0, sat=0, idx=0, out_valid=0, busy=0, in_ready=1.
REQ-029 Reset mid-ACC or mid-HOLD SHALL discard partial/held result; first word after release starts a new sum.
REQ-030 Reset deassertion SHALL need no clk edge to take effect; first transfer allowed on first edge after release.

Verification
REQ-031 N_WORDS=4, words 0x0001,0x0002,0x0003,0x0004 back-to-back -> out_valid one cycle after 4th accept, out_sum=0x000A, out_carries=0, out_sat=0.
REQ-032 N_WORDS=4, four 0xFFFF -> out_sum=0xFFFC, out_carries=3, out_sat=0.
REQ-033 Result ready, out_ready low 5 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> IDLE, next word accepted after one-cycle bubble.
REQ-034 N_WORDS=300, CNT_W=8, 300 x 0xFFFF -> out_sum=0xFED4, out_carries=255, out_sat=1.
REQ-035 clr after 2 of 4 words, then 1,1,1,1 -> out_sum=0x0004, carries=0; clr during HOLD with out_ready=1 -> out_valid drops, no transfer.
REQ-036 rst_n low asynchronously mid-ACC -> outputs reset without clock edge; 4 new words 0x0010 -> out_sum=0x0040.
